b2_serial_subtractor: RTL and testbench
=======================================

B2_SERIAL_SUBTRACTOR -- requirements
Module: b2_serial_subtractor

Interface
REQ-001 Parameter N, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clock  input  1  sole clock, all state updates on rising edge.
REQ-003 reset_  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-004 x  input  N  minuend, unsigned or two's complement.
REQ-005 y  input  N  subtrahend.
REQ-006 bin  input  1  borrow-in.
REQ-007 start  input  1  request, sampled only while ready=1.
REQ-008 ack  input  1  result acknowledge, sampled only while done=1.
REQ-009 ready  output  1  block idle, accepts start.
REQ-010 done  output  1  result valid on d/bout/ov.
REQ-011 d  output  N  difference x - y - bin mod 2^N.
REQ-012 bout  output  1  borrow-out (1 iff x < y + bin, unsigned).
REQ-013 ov  output  1  signed overflow of x - y - bin.

Function
REQ-014 States IDLE, CALC, DONE, one-hot or encoded; ready=1 exactly in IDLE, done=1 exactly in DONE.
REQ-015 IDLE, start=1 at edge k: latch x, y into shift registers, bin into borrow register, x[N-1]/y[N-1] into sign registers, clear bit counter, clear d; go to CALC.
REQ-016 IDLE, start=0: remain IDLE, all registers hold.
REQ-017 CALC, one bit per cycle, LSB first: a = x_sh[0], b = y_sh[0], br = borrow register.
REQ-018 Per bit: diff = a ^ b ^ br; borrow next = (~a & b) | (~(a ^ b) & br).
REQ-019 Per bit: diff shifted into d at MSB, d shifted right one place; x_sh, y_sh shifted right one place; counter incremented.
REQ-020 Edges k+1..k+N process bits 0..N-1; at edge k+N state becomes DONE; done=1 first visible after edge k+N (latency N+1 edges from start sample).
REQ-021 On entering DONE: bout = final borrow; ov = (sx != sy) & (d[N-1] != sx), using latched sign bits and final d.
REQ-022 d, bout, ov only updated at the transition into DONE and on reset; stable throughout DONE.
REQ-023 start during CALC or DONE ignored, no effect on operands or timing.
REQ-024 x, y, bin changes after the latching edge have no effect on the current result.
REQ-025 DONE, ack=1: return to IDLE at that edge; d, bout, ov hold their values in IDLE until next start.
REQ-026 DONE, ack=0: remain DONE indefinitely.
REQ-027 DONE, ack=1 and start=1 same edge: go to IDLE only; start not captured, must be reasserted with ready=1.
REQ-028 ack outside DONE ignored.
REQ-029 Counter wraps never; width ceil(log2(N+1)); CALC exits exactly after N bits for all legal N.

Reset
REQ-030 reset_=0 at a rising edge: state IDLE, ready=1, done=0, d=0, bout=0, ov=0, counter/shift/borrow/sign registers 0.
REQ-031 Reset has priority over start and ack in every state, including mid-CALC; partial result discarded.
REQ-032 First start accepted at the first edge with reset_=1 and start=1.

Verification (N=8)
REQ-033 x=0x05, y=0x03, bin=0, start one cycle -> done after 9 edges, d=0x02, bout=0, ov=0.
REQ-034 x=0x03, y=0x05, bin=0 -> d=0xFE, bout=1, ov=0; ack=0 held 20 cycles -> outputs stable, done=1.
REQ-035 x=0x80, y=0x01, bin=0 -> d=0x7F, bout=0, ov=1; x=0x00, y=0x00, bin=1 -> d=0xFF, bout=1, ov=0.
REQ-036 start with x=0x10, y=0x01; change x to 0xFF and pulse start during CALC -> result d=0x0F, latency unchanged, second start ignored.
REQ-037 reset_=0 for one edge at bit 4 of CALC -> next cycle ready=1, done=0, d=0x00, bout=0, ov=0; following start 0x09-0x04 -> d=0x05.
REQ-038 ack=1 and start=1 together in DONE -> IDLE, no new operation; ready=1, done stays 0 for 10 cycles.

Source files
------------

// File: rtl/b2_serial_subtractor.sv
// Bit-serial subtractor: computes x - y - bin one bit per clock, LSB first,
// with a start/ack handshake and borrow-out / signed-overflow flags.
module b2_serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         bin,
    input  logic         start,
    input  logic         ack,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         ov
);

    // state | meaning
    // IDLE  | waiting for start, last result held on d/bout/ov
    // CALC  | one difference bit per cycle, LSB first
    // DONE  | result valid, waiting for ack
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state_q;
    state_t        state_d;
    logic [N-1:0]  x_sh;
    logic [N-1:0]  y_sh;
    logic [N-1:0]  d_acc;
    logic [N-1:0]  d_q;
    logic [CW-1:0] cnt;
    logic          br;
    logic          sx;
    logic          sy;
    logic          bout_q;
    logic          ov_q;
    logic          a;
    logic          b;
    logic          diff;
    logic          br_next;
    logic          last_bit;

    always_comb begin
        a        = x_sh[0];
        b        = y_sh[0];
        diff     = a ^ b ^ br;
        br_next  = (~a & b) | (~(a ^ b) & br);
        last_bit = (cnt == LAST);
        state_d  = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = CALC;
            CALC:    if (last_bit) state_d = DONE;
            DONE:    if (ack)      state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // d_acc is the working shift register; d_q only changes when the
    // last bit lands, so the visible result never shows a partial value.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            x_sh   <= '0;
            y_sh   <= '0;
            d_acc  <= '0;
            d_q    <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            sx     <= 1'b0;
            sy     <= 1'b0;
            bout_q <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_sh  <= x;
                        y_sh  <= y;
                        br    <= bin;
                        sx    <= x[N-1];
                        sy    <= y[N-1];
                        cnt   <= '0;
                        d_acc <= '0;
                    end
                end
                CALC: begin
                    x_sh  <= x_sh >> 1;
                    y_sh  <= y_sh >> 1;
                    br    <= br_next;
                    d_acc <= {diff, d_acc[N-1:1]};
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        d_q    <= {diff, d_acc[N-1:1]};
                        bout_q <= br_next;
                        ov_q   <= (sx != sy) & (diff != sx);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign d     = d_q;
    assign bout  = bout_q;
    assign ov    = ov_q;

endmodule

// File: tb/tb_b2_serial_subtractor.sv
// Directed self-checking bench for b2_serial_subtractor with N=8.
module tb_b2_serial_subtractor;

    logic       clock;
    logic       reset_;
    logic [7:0] x;
    logic [7:0] y;
    logic       bin;
    logic       start;
    logic       ack;
    logic       ready;
    logic       done;
    logic [7:0] d;
    logic       bout;
    logic       ov;

    int errors = 0;
    int checks = 0;
    int lat;

    b2_serial_subtractor #(.N(8)) dut (
        .clock (clock),
        .reset_(reset_),
        .x     (x),
        .y     (y),
        .bin   (bin),
        .start (start),
        .ack   (ack),
        .ready (ready),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .ov    (ov)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then count edges until done (bounded).
    task automatic run_op(input logic [7:0] xv, input logic [7:0] yv, input logic bv,
                          output int latency);
        x     = xv;
        y     = yv;
        bin   = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", {31'd0, ready}, 32'd0);
        latency = 0;
        while (done !== 1'b1 && latency < 20) begin
            tick();
            latency++;
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        reset_ = 1'b0;
        x      = 8'h00;
        y      = 8'h00;
        bin    = 1'b0;
        start  = 1'b0;
        ack    = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_d",     {24'd0, d},     32'h00);
        check("rst_bout",  {31'd0, bout},  32'd0);
        check("rst_ov",    {31'd0, ov},    32'd0);
        reset_ = 1'b1;

        // 5 - 3
        run_op(8'h05, 8'h03, 1'b0, lat);
        check("lat_5m3",  lat,           32'd8);
        check("d_5m3",    {24'd0, d},    32'h02);
        check("bout_5m3", {31'd0, bout}, 32'd0);
        check("ov_5m3",   {31'd0, ov},   32'd0);
        do_ack();
        check("idle_ready", {31'd0, ready}, 32'd1);
        check("idle_done",  {31'd0, done},  32'd0);
        check("idle_hold_d", {24'd0, d},    32'h02);

        // 3 - 5, then hold DONE without ack
        run_op(8'h03, 8'h05, 1'b0, lat);
        check("lat_3m5",  lat,           32'd8);
        check("d_3m5",    {24'd0, d},    32'hFE);
        check("bout_3m5", {31'd0, bout}, 32'd1);
        check("ov_3m5",   {31'd0, ov},   32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_done", {31'd0, done}, 32'd1);
            check("hold_d",    {23'd0, bout, d}, 32'h1FE);
        end
        do_ack();

        // signed overflow: -128 - 1
        run_op(8'h80, 8'h01, 1'b0, lat);
        check("d_80m1",    {24'd0, d},    32'h7F);
        check("bout_80m1", {31'd0, bout}, 32'd0);
        check("ov_80m1",   {31'd0, ov},   32'd1);
        do_ack();

        // borrow-in only
        run_op(8'h00, 8'h00, 1'b1, lat);
        check("d_bin",    {24'd0, d},    32'hFF);
        check("bout_bin", {31'd0, bout}, 32'd1);
        check("ov_bin",   {31'd0, ov},   32'd0);
        do_ack();

        // operand change, stray start and stray ack during CALC
        x     = 8'h10;
        y     = 8'h01;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        x     = 8'hFF;
        y     = 8'hFF;
        bin   = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("lat_ignore", lat,           32'd8);
        check("d_ignore",   {24'd0, d},    32'h0F);
        check("bout_ignore", {31'd0, bout}, 32'd0);
        check("ov_ignore",  {31'd0, ov},   32'd0);
        do_ack();
        tick();
        check("no_restart", {31'd0, ready}, 32'd1);

        // reset in the middle of CALC (edge that would process bit 4)
        x     = 8'h33;
        y     = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset_ = 1'b0;
        tick();
        reset_ = 1'b1;
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_done",  {31'd0, done},  32'd0);
        check("midrst_d",     {24'd0, d},     32'h00);
        check("midrst_bout",  {31'd0, bout},  32'd0);
        check("midrst_ov",    {31'd0, ov},    32'd0);

        run_op(8'h09, 8'h04, 1'b0, lat);
        check("lat_9m4", lat,        32'd8);
        check("d_9m4",   {24'd0, d}, 32'h05);

        // ack and start together in DONE: back to IDLE only
        x     = 8'h55;
        y     = 8'h11;
        ack   = 1'b1;
        start = 1'b1;
        tick();
        ack   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("ackstart_ready", {31'd0, ready}, 32'd1);
            check("ackstart_done",  {31'd0, done},  32'd0);
            tick();
        end
        check("ackstart_d", {24'd0, d}, 32'h05);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
